// File: rtl/counter_interact_if.sv
// Penguin counter-interaction bus: coordinate/key inputs toward the block,
// held item, slot contents and action strobes back out.
interface counter_interact_if;
    logic [9:0]  nearestCounterX;
    logic [9:0]  nearestCounterY;
    logic        interactKey;
    logic        chopKey;
    logic        frameTick;
    logic [1:0]  heldItem;
    logic [31:0] slotItems;
    logic [7:0]  chopProgress;
    logic        actionPulse;
    logic [1:0]  actionType;

    modport master (
        output nearestCounterX, nearestCounterY, interactKey, chopKey, frameTick,
        input  heldItem, slotItems, chopProgress, actionPulse, actionType
    );

    modport slave (
        input  nearestCounterX, nearestCounterY, interactKey, chopKey, frameTick,
        output heldItem, slotItems, chopProgress, actionPulse, actionType
    );
endinterface

// File: rtl/counter_interact.sv
// Counter interaction: pick/place items on a row of 16 wall counters,
// slot 0 is an endless fish crate, slot 15 is the chopping board.

// One counter slot; written only by the interaction FSM.
module counter_slot (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       wr_en,
    input  logic [1:0] wr_data,
    output logic [1:0] code
);
    // slot content register, cleared to empty on reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)   code <= 2'd0;
        else if (wr_en) code <= wr_data;
    end
endmodule

module counter_interact #(
    parameter int COUNTER_Y   = 100,
    parameter int SLOT_W      = 40,
    parameter int CHOP_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset_n,
    counter_interact_if.slave bus
);
    localparam int NUM_SLOTS = 16;
    localparam logic [3:0] BOARD = 4'd15;

    localparam logic [1:0] IT_NONE   = 2'd0;
    localparam logic [1:0] IT_FISH   = 2'd1;
    localparam logic [1:0] IT_CHOPPED = 2'd2;

    localparam logic [1:0] A_REJECT = 2'd0;
    localparam logic [1:0] A_PICK   = 2'd1;
    localparam logic [1:0] A_PLACE  = 2'd2;
    localparam logic [1:0] A_CHOP   = 2'd3;

    typedef enum logic [2:0] {IDLE, DECODE, ACT, CHOP, WAIT_RELEASE} state_t;

    typedef struct packed {
        logic       ok;
        logic [3:0] idx;
    } slot_addr_t;

    // Match against each slot's X directly instead of dividing by SLOT_W;
    // candidates beyond X=620 are never valid.
    function automatic slot_addr_t decode(input logic [9:0] x, input logic [9:0] y);
        slot_addr_t a;
        a = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (({22'd0, y} == 32'(COUNTER_Y)) &&
                ({22'd0, x} == 32'(20 + i * SLOT_W)) &&
                ((20 + i * SLOT_W) <= 620)) begin
                a.ok  = 1'b1;
                a.idx = 4'(i);
            end
        end
        return a;
    endfunction

    state_t     state, state_d;
    logic       key_q;
    logic       armed;
    logic [9:0] lat_x, lat_y;
    logic       latch;
    logic [1:0] held, held_d;
    logic [7:0] prog, prog_d, prog_inc;
    logic       pulse, pulse_d;
    logic [1:0] atype, atype_d;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [1:0] wr_data;
    logic [1:0] cur;
    logic       int_edge;
    logic       on_board;

    logic [NUM_SLOTS-1:0][1:0] slots;
    slot_addr_t live_a, lat_a;

    assign live_a   = decode(bus.nearestCounterX, bus.nearestCounterY);
    assign lat_a    = decode(lat_x, lat_y);
    assign on_board = live_a.ok && (live_a.idx == BOARD);
    assign cur      = slots[lat_a.idx];
    assign prog_inc = (prog == 8'hFF) ? prog : prog + 8'd1;

    // armed stays low for the first cycle out of reset so a key already
    // held through reset is seen as high history, not a fresh press
    assign int_edge = armed & bus.interactKey & ~key_q;

    // the crate never empties
    assign slots[0] = IT_FISH;

    genvar g;
    generate
        for (g = 1; g < NUM_SLOTS; g++) begin : g_slot
            counter_slot u_slot (
                .Clk     (Clk),
                .Reset_n (Reset_n),
                .wr_en   (wr_en && (wr_idx == 4'(g))),
                .wr_data (wr_data),
                .code    (slots[g])
            );
        end
    endgenerate

    // state, key history, latched coordinates and action registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            key_q <= 1'b0;
            armed <= 1'b0;
            lat_x <= '0;
            lat_y <= '0;
            held  <= IT_NONE;
            prog  <= '0;
            pulse <= 1'b0;
            atype <= A_REJECT;
        end else begin
            state <= state_d;
            key_q <= bus.interactKey;
            armed <= 1'b1;
            if (latch) begin
                lat_x <= bus.nearestCounterX;
                lat_y <= bus.nearestCounterY;
            end
            held  <= held_d;
            prog  <= prog_d;
            pulse <= pulse_d;
            atype <= atype_d;
        end
    end

    // next state, slot write and action outcome
    always_comb begin
        state_d = state;
        held_d  = held;
        prog_d  = prog;
        pulse_d = 1'b0;
        atype_d = atype;
        latch   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = lat_a.idx;
        wr_data = IT_NONE;
        case (state)
            IDLE: begin
                if (int_edge) begin
                    state_d = DECODE;
                    latch   = 1'b1;
                end else if (bus.chopKey && on_board && slots[15] == IT_FISH) begin
                    state_d = CHOP;
                    prog_d  = '0;
                end
            end
            DECODE: begin
                if (lat_a.ok) begin
                    state_d = ACT;
                end else begin
                    state_d = WAIT_RELEASE;
                    pulse_d = 1'b1;
                    atype_d = A_REJECT;
                end
            end
            ACT: begin
                state_d = WAIT_RELEASE;
                pulse_d = 1'b1;
                if (held == IT_NONE && cur != IT_NONE) begin
                    held_d  = cur;
                    wr_en   = (lat_a.idx != 4'd0);
                    wr_data = IT_NONE;
                    atype_d = A_PICK;
                end else if (held != IT_NONE && cur == IT_NONE && lat_a.idx != 4'd0) begin
                    held_d  = IT_NONE;
                    wr_en   = 1'b1;
                    wr_data = held;
                    atype_d = A_PLACE;
                end else begin
                    atype_d = A_REJECT;
                end
            end
            CHOP: begin
                if (!bus.chopKey || !on_board) begin
                    state_d = IDLE;
                    prog_d  = '0;
                end else if (bus.frameTick) begin
                    if ({24'd0, prog_inc} == 32'(CHOP_FRAMES)) begin
                        state_d = WAIT_RELEASE;
                        prog_d  = '0;
                        wr_en   = 1'b1;
                        wr_idx  = BOARD;
                        wr_data = IT_CHOPPED;
                        pulse_d = 1'b1;
                        atype_d = A_CHOP;
                    end else begin
                        prog_d = prog_inc;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!bus.interactKey && !bus.chopKey) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.heldItem     = held;
    assign bus.slotItems    = slots;
    assign bus.chopProgress = prog;
    assign bus.actionPulse  = pulse;
    assign bus.actionType   = atype;
endmodule

// File: doc/counter_interact.md
COUNTER_INTERACT -- requirements
Module: counter_interact

Interface
REQ-001 The block SHALL have parameter COUNTER_Y, default 100, meaning the Y coordinate of the top-wall counter row.
REQ-002 The block SHALL have parameter SLOT_W, default 40, meaning the counter pitch in pixels.
REQ-003 The block SHALL have parameter CHOP_FRAMES, default 30, meaning the frame ticks of chopping needed to finish a fish.
REQ-004 Clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 nearestCounterX  input  10  nearest counter X from the upstream nearest-counter stage; 15 means no counter.
REQ-007 nearestCounterY  input  10  nearest counter Y; 15 means no counter.
REQ-008 interactKey  input  1  level of the pick/place key, synchronous to Clk.
REQ-009 chopKey  input  1  level of the chop key, synchronous to Clk.
REQ-010 frameTick  input  1  one-cycle pulse per video frame.
REQ-011 heldItem  output  2  item carried by the penguin: 0 none, 1 fish, 2 chopped fish, 3 plate.
REQ-012 slotItems  output  32  16 packed 2-bit slot codes; slot i occupies bits [2i+1:2i].
REQ-013 chopProgress  output  8  frame ticks accumulated on the current chop.
REQ-014 actionPulse  output  1  one-cycle strobe when an action completes.
REQ-015 actionType  output  2  action qualified by actionPulse: 0 reject, 1 pick, 2 place, 3 chop done.

Function
REQ-016 Coordinates SHALL be valid only when Y == COUNTER_Y, X >= 20, X <= 620 and (X-20) mod SLOT_W == 0; slot index = (X-20)/SLOT_W, 0..15.
REQ-017 Slot 0 SHALL be a fish crate: its slotItems field always reads 1, picking from it never empties it, and placing onto it is rejected.
REQ-018 Slot 15 SHALL be the chopping board; all other slots are plain counters.
REQ-019 The FSM SHALL have states IDLE, DECODE, ACT, CHOP, WAIT_RELEASE.
REQ-020 Interact edge = interactKey high this cycle and low the previous cycle, from a registered copy of the key.
REQ-021 In IDLE, an interact edge SHALL go to DECODE and latch both coordinates.
REQ-022 In IDLE with no interact edge, chopKey high plus a valid slot-15 address plus slot 15 == 1 SHALL go to CHOP with chopProgress = 0.
REQ-023 When an interact edge and the chop conditions are both true in IDLE, the interact edge SHALL win.
REQ-024 DECODE SHALL take one cycle, then go to ACT if the latched coordinates are valid, or to WAIT_RELEASE with a reject pulse if not.
REQ-025 ACT pick: held empty and slot nonempty gives held = slot code and slot = 0 (slot 0 excepted), actionType 1.
REQ-026 ACT place: held nonempty, slot empty and slot != 0 gives slot = held and held = 0, actionType 2.
REQ-027 ACT other cases SHALL change no state and give actionType 0.
REQ-028 ACT SHALL always go to WAIT_RELEASE.
REQ-029 Latency: an edge sampled at clock k SHALL make heldItem, slotItems and actionPulse change after edge k+2.
REQ-030 actionPulse SHALL be high exactly one cycle per action.
REQ-031 CHOP SHALL increment chopProgress on each frameTick, saturating at 255.
REQ-032 In CHOP, releasing chopKey or the address leaving slot 15 SHALL return to IDLE, clear chopProgress and leave slot 15 unchanged.
REQ-033 When chopProgress reaches CHOP_FRAMES, the block SHALL set slot 15 = 2, pulse actionType 3, clear chopProgress and go to WAIT_RELEASE.
REQ-034 Interact edges in CHOP, DECODE, ACT or WAIT_RELEASE SHALL be ignored.
REQ-035 WAIT_RELEASE SHALL return to IDLE only when interactKey and chopKey are both low.

Reset
REQ-036 Reset_n low SHALL immediately force IDLE, heldItem = 0, all slots 1..15 = 0, chopProgress = 0, actionPulse = 0, actionType = 0 and the key history register = 0, including mid-action and mid-chop.
REQ-037 After Reset_n deasserts, a key already held high SHALL NOT count as an edge.

Verification
REQ-038 Bench: X = 20, Y = 100, interact edge -> 2 cycles later heldItem = 1, slot 0 still 1, actionPulse one cycle, actionType 1.
REQ-039 Bench: holding fish, X = 620, Y = 100, edge -> slot 15 = 1, heldItem = 0, actionType 2; then chopKey held for 30 frameTicks -> slot 15 = 2, actionType 3.
REQ-040 Bench: X = 15, Y = 15, edge -> actionType 0 and no state change; X = 30, Y = 100 -> reject.
REQ-041 Bench: chop released at tick 10 -> chopProgress = 0 and slot 15 stays 1; interactKey held 100 cycles -> exactly one action.
REQ-042 Bench: Reset_n pulsed low during CHOP at tick 20 -> all outputs at reset values in the same cycle; no actionPulse after release.
